mxrv_trap_ctrl: RTL and testbench

//  Machine-mode trap sequencer between decode/execute, mxrv_csr_reg and mxrv_pc_reg.
//  On ecall, ebreak or an enabled external interrupt it:
//   - stalls the pipeline;
//   - writes mepc, mcause and mstatus through its own CSR write port;
//   - redirects the PC to mtvec.
//  On mret it restores mstatus and redirects the PC to mepc.
//  It owns the CSR write port only while csr_busy_o=1; the EX-stage CSR writer is muxed out then.

---
 rtl/mxrv_trap_if.sv | 37 +++
 rtl/mxrv_trap_ctrl.sv | 126 ++++++++++++
 tb/tb_mxrv_trap_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mxrv_trap_if.sv
// Trap controller port bundle: decode events, CSR side-band reads,
// the shared CSR write port and the PC redirect/stall outputs.
interface mxrv_trap_if #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
);
  logic              ecall_i;
  logic              ebreak_i;
  logic              mret_i;
  logic              int_req_i;
  logic [XLEN-1:0]   inst_addr_i;
  logic [XLEN-1:0]   csr_mtvec_i;
  logic [XLEN-1:0]   csr_mepc_i;
  logic [XLEN-1:0]   csr_mstatus_i;
  logic              csr_we_o;
  logic [CSR_AW-1:0] csr_waddr_o;
  logic [XLEN-1:0]   csr_wdata_o;
  logic              csr_busy_o;
  logic              hold_flag_o;
  logic              jump_flag_o;
  logic [XLEN-1:0]   jump_addr_o;

  // master: the trap controller; slave: the surrounding core
  modport master (
    input  ecall_i, ebreak_i, mret_i, int_req_i, inst_addr_i,
           csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, csr_busy_o,
           hold_flag_o, jump_flag_o, jump_addr_o
  );

  modport slave (
    output ecall_i, ebreak_i, mret_i, int_req_i, inst_addr_i,
           csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, csr_busy_o,
           hold_flag_o, jump_flag_o, jump_addr_o
  );
endinterface

// File: rtl/mxrv_trap_ctrl.sv
// Machine-mode trap sequencer: saves mepc/mcause/mstatus and redirects to
// mtvec on ecall/ebreak/interrupt; restores mstatus and returns on mret.
module mxrv_trap_ctrl #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic         clk,
  input  logic         rst,
  mxrv_trap_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, R_MSTATUS, JUMP
  } state_t;

  localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);

  localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(32'd11);
  localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(32'd3);
  localparam logic [XLEN-1:0] CAUSE_IRQ    = XLEN'(32'h8000_000B);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, mst_q, cause_q, mepc_q;
  logic              mret_q;

  logic              irq, take_trap, take_mret;
  logic              we;
  logic [CSR_AW-1:0] waddr;
  logic [XLEN-1:0]   wdata;
  logic              jflag;
  logic [XLEN-1:0]   jaddr;

  assign irq       = bus.int_req_i & bus.csr_mstatus_i[3];
  assign take_trap = (state_q == IDLE) & (bus.ecall_i | bus.ebreak_i | irq);
  assign take_mret = (state_q == IDLE) & ~(bus.ecall_i | bus.ebreak_i | irq) & bus.mret_i;

  // NOTE: non-blocking assignments for all registered state, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      mst_q   <= '0;
      cause_q <= '0;
      mepc_q  <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_trap | take_mret) begin
        pc_q    <= bus.inst_addr_i;
        mst_q   <= bus.csr_mstatus_i;
        mepc_q  <= bus.csr_mepc_i;
        mret_q  <= take_mret;
        cause_q <= bus.ecall_i  ? CAUSE_ECALL  :
                   bus.ebreak_i ? CAUSE_EBREAK :
                   take_trap    ? CAUSE_IRQ    : '0;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    jflag   = 1'b0;
    jaddr   = '0;
    unique case (state_q)
      IDLE: begin
        if (take_trap)      state_d = W_MEPC;
        else if (take_mret) state_d = R_MSTATUS;
      end
      W_MEPC: begin
        we      = 1'b1;
        waddr   = ADDR_MEPC;
        wdata   = pc_q;
        state_d = W_MCAUSE;
      end
      W_MCAUSE: begin
        we      = 1'b1;
        waddr   = ADDR_MCAUSE;
        wdata   = cause_q;
        state_d = W_MSTATUS;
      end
      W_MSTATUS: begin
        // MPIE <= MIE, MIE <= 0
        we       = 1'b1;
        waddr    = ADDR_MSTATUS;
        wdata    = mst_q;
        wdata[7] = mst_q[3];
        wdata[3] = 1'b0;
        state_d  = JUMP;
      end
      R_MSTATUS: begin
        // MIE <= MPIE, MPIE <= 1
        we       = 1'b1;
        waddr    = ADDR_MSTATUS;
        wdata    = mst_q;
        wdata[3] = mst_q[7];
        wdata[7] = 1'b1;
        state_d  = JUMP;
      end
      JUMP: begin
        jflag   = 1'b1;
        jaddr   = mret_q ? mepc_q : {bus.csr_mtvec_i[XLEN-1:2], 2'b00};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.csr_we_o    = we;
  assign bus.csr_waddr_o = waddr;
  assign bus.csr_wdata_o = wdata;
  assign bus.jump_flag_o = jflag;
  assign bus.jump_addr_o = jaddr;
  assign bus.csr_busy_o  = (state_q != IDLE);
  // The accept-cycle stall is combinational from the event pulses; keep it
  // quiet while reset is held.
  assign bus.hold_flag_o = ~rst & ((state_q != IDLE) | take_trap | take_mret);

endmodule

// File: tb/tb_mxrv_trap_ctrl.sv
// Self-checking bench for mxrv_trap_ctrl: directed scenarios plus random
// events, compared cycle by cycle against a queue-based reference model.
module tb_mxrv_trap_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mxrv_trap_if #(.XLEN(32), .CSR_AW(12)) bus ();
  mxrv_trap_ctrl #(.XLEN(32), .CSR_AW(12)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Emulated CSR file feeding the side-band read inputs
  logic [31:0] mtvec_r, mepc_r, mstatus_r, mcause_r;
  assign bus.csr_mtvec_i   = mtvec_r;
  assign bus.csr_mepc_i    = mepc_r;
  assign bus.csr_mstatus_i = mstatus_r;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        jump;
    logic        use_mtvec;
    logic [31:0] jaddr;
  } exp_t;

  exp_t        seq_q[$];
  logic [11:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          jumps, hold_cycles;
  logic [31:0] last_jaddr;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    jumps       = 0;
    hold_cycles = 0;
    last_jaddr  = '0;
  endtask

  function automatic exp_t wr(input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    e      = '0;
    e.we   = 1'b1;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  // One clock: entered at posedge+1 with inputs set, checks at negedge,
  // advances the model after the next posedge.
  task automatic step();
    exp_t e;
    logic busy_e, hold_e, irq, acc_t, acc_m;
    logic [31:0] m;
    e      = '0;
    busy_e = 1'b0;
    hold_e = 1'b0;
    irq    = bus.int_req_i & mstatus_r[3];
    acc_t  = bus.ecall_i | bus.ebreak_i | irq;
    acc_m  = !acc_t & bus.mret_i;
    if (!rst) begin
      if (seq_q.size() > 0) begin
        e      = seq_q[0];
        busy_e = 1'b1;
        hold_e = 1'b1;
        if (e.use_mtvec) e.jaddr = mtvec_r & ~32'h3;
      end else begin
        hold_e = acc_t | acc_m;
      end
    end
    #4;
    check("hold",  bus.hold_flag_o, hold_e);
    check("busy",  bus.csr_busy_o,  busy_e);
    check("we",    bus.csr_we_o,    e.we);
    check("waddr", bus.csr_waddr_o, e.addr);
    check("wdata", bus.csr_wdata_o, e.data);
    check("jump",  bus.jump_flag_o, e.jump);
    check("jaddr", bus.jump_addr_o, e.jaddr);
    if (bus.csr_we_o) begin
      wa_q.push_back(bus.csr_waddr_o);
      wd_q.push_back(bus.csr_wdata_o);
    end
    if (bus.jump_flag_o) begin
      jumps++;
      last_jaddr = bus.jump_addr_o;
    end
    if (bus.hold_flag_o) hold_cycles++;
    @(posedge clk);
    #1;
    if (rst) begin
      seq_q.delete();
    end else if (busy_e) begin
      if (e.we) begin
        case (e.addr)
          12'h300: mstatus_r = e.data;
          12'h341: mepc_r    = e.data;
          12'h342: mcause_r  = e.data;
          default: ;
        endcase
      end
      void'(seq_q.pop_front());
    end else if (acc_t) begin
      m = mstatus_r;
      seq_q.push_back(wr(12'h341, bus.inst_addr_i));
      seq_q.push_back(wr(12'h342, bus.ecall_i ? 32'd11 : bus.ebreak_i ? 32'd3 : 32'h8000_000B));
      seq_q.push_back(wr(12'h300, (m & ~32'h88) | (32'(m[3]) << 7)));
      e = '0; e.jump = 1'b1; e.use_mtvec = 1'b1;
      seq_q.push_back(e);
    end else if (acc_m) begin
      m = mstatus_r;
      seq_q.push_back(wr(12'h300, (m & ~32'h88) | (32'(m[7]) << 3) | 32'h80));
      e = '0; e.jump = 1'b1; e.jaddr = mepc_r;
      seq_q.push_back(e);
    end
  endtask

  initial begin
    int mc;
    rst = 1'b1;
    bus.ecall_i = 0; bus.ebreak_i = 0; bus.mret_i = 0; bus.int_req_i = 0;
    bus.inst_addr_i = '0;
    mtvec_r = '0; mepc_r = '0; mstatus_r = '0; mcause_r = '0;
    clear_log();
    @(posedge clk); #1;
    repeat (5) step();
    rst = 1'b0;

    // ecall
    bus.inst_addr_i = 32'h100; mtvec_r = 32'h801; mstatus_r = 32'h8;
    clear_log();
    bus.ecall_i = 1; step(); bus.ecall_i = 0;
    repeat (5) step();
    check("ecall_nwr", wa_q.size(), 3);
    if (wa_q.size() == 3) begin
      check("ecall_a0", wa_q[0], 12'h341); check("ecall_d0", wd_q[0], 32'h100);
      check("ecall_a1", wa_q[1], 12'h342); check("ecall_d1", wd_q[1], 32'hB);
      check("ecall_a2", wa_q[2], 12'h300); check("ecall_d2", wd_q[2], 32'h80);
    end
    check("ecall_jumps", jumps, 1);
    check("ecall_jaddr", last_jaddr, 32'h800);
    check("ecall_hold", hold_cycles, 5);

    // interrupt gating
    bus.int_req_i = 1; mstatus_r = 32'h0;
    clear_log();
    repeat (4) step();
    check("irq_masked_nwr", wa_q.size(), 0);
    check("irq_masked_hold", hold_cycles, 0);
    mstatus_r = 32'h8;
    repeat (6) step();
    check("irq_nwr", wa_q.size(), 3);
    if (wd_q.size() > 1) check("irq_mcause", wd_q[1], 32'h8000_000B);
    clear_log();
    repeat (6) step();
    check("irq_no_reentry", wa_q.size(), 0);
    bus.int_req_i = 0;

    // mret
    mepc_r = 32'h104; mstatus_r = 32'h80;
    clear_log();
    bus.mret_i = 1; step(); bus.mret_i = 0;
    repeat (3) step();
    check("mret_nwr", wa_q.size(), 1);
    if (wa_q.size() > 0) begin
      check("mret_a", wa_q[0], 12'h300);
      check("mret_d", wd_q[0], 32'h88);
    end
    check("mret_jaddr", last_jaddr, 32'h104);
    check("mret_hold", hold_cycles, 3);

    // priority and ignored event while busy
    mstatus_r = 32'h8;
    clear_log();
    bus.ecall_i = 1; bus.int_req_i = 1; step();
    bus.ecall_i = 0; bus.int_req_i = 0; bus.ebreak_i = 1; step();
    bus.ebreak_i = 0;
    repeat (5) step();
    mc = 0;
    foreach (wa_q[i]) if (wa_q[i] == 12'h342) begin
      mc++;
      check("prio_mcause", wd_q[i], 32'd11);
    end
    check("prio_mcause_cnt", mc, 1);

    // back-to-back ecall then mret on first idle cycle
    mstatus_r = 32'h8;
    clear_log();
    bus.ecall_i = 1; step(); bus.ecall_i = 0;
    repeat (4) step();
    bus.mret_i = 1; step(); bus.mret_i = 0;
    repeat (3) step();
    check("b2b_nwr", wa_q.size(), 4);
    check("b2b_jumps", jumps, 2);

    // reset in W_MCAUSE
    clear_log();
    bus.ecall_i = 1; step(); bus.ecall_i = 0;
    step();
    rst = 1'b1; step();
    rst = 1'b0;
    repeat (3) step();
    check("rst_mid_nwr", wa_q.size(), 1);
    check("rst_mid_jumps", jumps, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.ecall_i  = ($urandom_range(0, 9) == 0);
      bus.ebreak_i = ($urandom_range(0, 11) == 0);
      bus.mret_i   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) bus.int_req_i = ~bus.int_req_i;
      bus.inst_addr_i = $urandom;
      if ($urandom_range(0, 3) == 0) mtvec_r = $urandom;
      if ($urandom_range(0, 5) == 0) mstatus_r = $urandom;
      if ($urandom_range(0, 5) == 0) mepc_r = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
